// File: rtl/commit_unit_p_if.sv
`default_nettype none
// ============================================================================
//  Module   : commit_unit_p_if
//  Brief    : ROB-head / memory-side bundle of the commit unit.
//             master = environment side, slave = commit unit side.
//  Revision : 1.0  initial release
// ============================================================================
interface commit_unit_p_if #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int FID_W = 8,
  parameter int DST_W = 5,
  parameter int DLY_W = 4
);
  logic             i_flush;
  logic             i_valid;
  logic             i_ready;
  logic [XLEN-1:0]  i_pc;
  logic [ROB_W-1:0] i_rob;
  logic [DST_W-1:0] i_dst;
  logic [XLEN-1:0]  i_value;
  logic [FID_W-1:0] i_fid;
  logic             i_load;
  logic             i_store;
  logic             i_lssigned;
  logic [1:0]       i_lswidth;
  logic             i_lsmiss;
  logic [DLY_W-1:0] i_cmtdelay;
  logic             i_bco_valid;
  logic             i_bco_taken;
  logic [1:0]       i_bco_pattern;
  logic [XLEN-1:0]  i_bco_target;
  logic             i_snoop_qhit;
  logic             s_busy_uncached_store;
  logic             i_mem_readyn;
  logic             i_lb_qhit;
  logic [XLEN-1:0]  i_lb_qdata;

  logic [XLEN-1:0]  o_snoop_qaddr;
  logic [XLEN-1:0]  o_lb_qaddr;
  logic             o_en;
  logic             o_store;
  logic [FID_W-1:0] o_fid;
  logic [DST_W-1:0] o_dst;
  logic [XLEN-1:0]  o_result;
  logic             o_mem_store_en;
  logic             o_rdctrl_en;
  logic             o_rdctrl_uncached;
  logic [FID_W-1:0] o_rdctrl_fid;
  logic [XLEN-1:0]  o_rdctrl_addr;
  logic [1:0]       o_rdctrl_lswidth;
  logic             o_nowb_en;
  logic [ROB_W-1:0] o_nowb_rob;
  logic [XLEN-1:0]  o_nowb_value;
  logic             o_bco_valid;
  logic             o_bco_taken;
  logic [1:0]       o_bco_pattern;
  logic [XLEN-1:0]  o_bco_pc;
  logic [XLEN-1:0]  o_bco_target;

  modport master (
    output i_flush, i_valid, i_ready, i_pc, i_rob, i_dst, i_value, i_fid,
           i_load, i_store, i_lssigned, i_lswidth, i_lsmiss, i_cmtdelay,
           i_bco_valid, i_bco_taken, i_bco_pattern, i_bco_target,
           i_snoop_qhit, s_busy_uncached_store, i_mem_readyn,
           i_lb_qhit, i_lb_qdata,
    input  o_snoop_qaddr, o_lb_qaddr, o_en, o_store, o_fid, o_dst, o_result,
           o_mem_store_en, o_rdctrl_en, o_rdctrl_uncached, o_rdctrl_fid,
           o_rdctrl_addr, o_rdctrl_lswidth, o_nowb_en, o_nowb_rob,
           o_nowb_value, o_bco_valid, o_bco_taken, o_bco_pattern, o_bco_pc,
           o_bco_target
  );

  modport slave (
    input  i_flush, i_valid, i_ready, i_pc, i_rob, i_dst, i_value, i_fid,
           i_load, i_store, i_lssigned, i_lswidth, i_lsmiss, i_cmtdelay,
           i_bco_valid, i_bco_taken, i_bco_pattern, i_bco_target,
           i_snoop_qhit, s_busy_uncached_store, i_mem_readyn,
           i_lb_qhit, i_lb_qdata,
    output o_snoop_qaddr, o_lb_qaddr, o_en, o_store, o_fid, o_dst, o_result,
           o_mem_store_en, o_rdctrl_en, o_rdctrl_uncached, o_rdctrl_fid,
           o_rdctrl_addr, o_rdctrl_lswidth, o_nowb_en, o_nowb_rob,
           o_nowb_value, o_bco_valid, o_bco_taken, o_bco_pattern, o_bco_pc,
           o_bco_target
  );
endinterface
`default_nettype wire

// File: rtl/commit_unit_p.sv
`default_nettype none
// ============================================================================
//  Module   : commit_unit_p
//  Brief    : Commits the ROB head, releases stores, refills missed loads
//             through a small IDLE/REQ/WAIT machine and replays branch
//             override info one cycle after the delay-slot commit.
//  Revision : 1.0  initial release
// ============================================================================
module commit_unit_p #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int FID_W = 8,
  parameter int DST_W = 5,
  parameter int DLY_W = 4
) (
  input  logic           clk,
  input  logic           resetn,
  commit_unit_p_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_base;
  logic             w_commit;
  logic             w_miss_commit;
  logic             w_go_req;
  logic [XLEN-1:0]  w_paddr;
  logic             w_unc;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [XLEN-1:0]  w_miss_res;

  logic [XLEN-1:0]  r_paddr;
  logic             r_unc;
  logic [FID_W-1:0] r_fid;
  logic [1:0]       r_lsw;
  logic             r_nowb_en;
  logic [ROB_W-1:0] r_nowb_rob;
  logic [XLEN-1:0]  r_nowb_value;
  logic             r_pending;
  logic             r_bco_taken_l;
  logic [1:0]       r_bco_pattern_l;
  logic [XLEN-1:0]  r_bco_pc_l;
  logic [XLEN-1:0]  r_bco_target_l;
  logic             r_bco_valid;
  logic             r_bco_taken;
  logic [1:0]       r_bco_pattern;
  logic [XLEN-1:0]  r_bco_pc;
  logic [XLEN-1:0]  r_bco_target;

  // Address translation: kseg1-style window maps to low memory, bit 29 = uncached
  always_comb begin
    w_paddr = bus.i_value;
    w_unc   = 1'b0;
    if (bus.i_value[31:30] == 2'b10) begin
      w_paddr       = '0;
      w_paddr[28:0] = bus.i_value[28:0];
      w_unc         = bus.i_value[29];
    end
  end

  // Extract the missed load's byte/half from the load-buffer word and extend it
  always_comb begin
    w_byte = bus.i_lb_qdata[7:0];
    case (r_paddr[1:0])
      2'd0:    w_byte = bus.i_lb_qdata[7:0];
      2'd1:    w_byte = bus.i_lb_qdata[15:8];
      2'd2:    w_byte = bus.i_lb_qdata[23:16];
      default: w_byte = bus.i_lb_qdata[31:24];
    endcase
    w_half = r_paddr[1] ? bus.i_lb_qdata[31:16] : bus.i_lb_qdata[15:0];
    case (bus.i_lswidth)
      2'b00:   w_miss_res = {{(XLEN-8){bus.i_lssigned & w_byte[7]}}, w_byte};
      2'b01:   w_miss_res = {{(XLEN-16){bus.i_lssigned & w_half[15]}}, w_half};
      default: w_miss_res = bus.i_lb_qdata;
    endcase
  end

  // Commit decision and load-miss next state; flush overrides everything
  always_comb begin
    w_base = bus.i_valid & bus.i_ready & (bus.i_cmtdelay == '0) &
             ~r_bco_valid & ~bus.i_snoop_qhit & ~bus.i_flush;
    w_state_nxt   = r_state;
    w_commit      = 1'b0;
    w_miss_commit = 1'b0;
    w_go_req      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_base) begin
          if (bus.i_store)     w_commit = ~bus.i_mem_readyn;
          else if (bus.i_load) w_commit = ~bus.i_lsmiss;
          else                 w_commit = 1'b1;
        end
        if (w_base & bus.i_load & bus.i_lsmiss &
            ~(w_unc & bus.s_busy_uncached_store)) begin
          w_go_req    = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_base & bus.i_lb_qhit) begin
          w_commit      = 1'b1;
          w_miss_commit = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.i_flush) w_state_nxt = S_IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Capture the refill request fields when the miss is accepted
  always_ff @(posedge clk) begin
    if (w_go_req) begin
      r_paddr <= w_paddr;
      r_unc   <= w_unc;
      r_fid   <= bus.i_fid;
      r_lsw   <= bus.i_lswidth;
    end
  end

  // Late writeback of the refilled load, one cycle after its commit
  always_ff @(posedge clk) begin
    if (!resetn) r_nowb_en <= 1'b0;
    else         r_nowb_en <= w_miss_commit;
    r_nowb_rob   <= bus.i_rob;
    r_nowb_value <= w_miss_res;
  end

  // Branch override: latch at branch commit, publish after the delay slot
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pending   <= 1'b0;
      r_bco_valid <= 1'b0;
    end else begin
      r_bco_valid <= w_commit & r_pending;
      if (bus.i_flush)                         r_pending <= 1'b0;
      else if (w_commit & r_pending)           r_pending <= 1'b0;
      else if (w_commit & bus.i_bco_valid)     r_pending <= 1'b1;
    end
    if (w_commit & ~r_pending & bus.i_bco_valid) begin
      r_bco_pc_l      <= bus.i_pc;
      r_bco_pattern_l <= bus.i_bco_pattern;
      r_bco_taken_l   <= bus.i_bco_taken;
      r_bco_target_l  <= bus.i_bco_target;
    end
    if (w_commit & r_pending) begin
      r_bco_pc      <= r_bco_pc_l;
      r_bco_pattern <= r_bco_pattern_l;
      r_bco_taken   <= r_bco_taken_l;
      r_bco_target  <= r_bco_target_l;
    end
  end

  assign bus.o_snoop_qaddr     = bus.i_pc;
  assign bus.o_lb_qaddr        = r_paddr;
  assign bus.o_en              = w_commit;
  assign bus.o_store           = w_commit & bus.i_store;
  assign bus.o_fid             = bus.i_fid;
  assign bus.o_dst             = bus.i_dst;
  assign bus.o_result          = w_miss_commit ? w_miss_res : bus.i_value;
  assign bus.o_mem_store_en    = w_commit & bus.i_store;
  assign bus.o_rdctrl_en       = (r_state == S_REQ) & ~bus.i_flush;
  assign bus.o_rdctrl_uncached = r_unc;
  assign bus.o_rdctrl_fid      = r_fid;
  assign bus.o_rdctrl_addr     = r_paddr;
  assign bus.o_rdctrl_lswidth  = r_lsw;
  assign bus.o_nowb_en         = r_nowb_en;
  assign bus.o_nowb_rob        = r_nowb_rob;
  assign bus.o_nowb_value      = r_nowb_value;
  assign bus.o_bco_valid       = r_bco_valid;
  assign bus.o_bco_taken       = r_bco_taken;
  assign bus.o_bco_pattern     = r_bco_pattern;
  assign bus.o_bco_pc          = r_bco_pc;
  assign bus.o_bco_target      = r_bco_target;

endmodule
`default_nettype wire

// File: tb/tb_commit_unit_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_commit_unit_p
//  Brief    : Directed self-checking bench for commit_unit_p.
//  Revision : 1.0  initial release
// ============================================================================
module tb_commit_unit_p;
  logic clk;
  logic resetn;
  int   total;
  int   bad;

  commit_unit_p_if bus ();

  commit_unit_p dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.i_flush = 0; bus.i_valid = 0; bus.i_ready = 0; bus.i_pc = '0;
    bus.i_rob = '0; bus.i_dst = '0; bus.i_value = '0; bus.i_fid = '0;
    bus.i_load = 0; bus.i_store = 0; bus.i_lssigned = 0; bus.i_lswidth = 2'b10;
    bus.i_lsmiss = 0; bus.i_cmtdelay = '0; bus.i_bco_valid = 0;
    bus.i_bco_taken = 0; bus.i_bco_pattern = '0; bus.i_bco_target = '0;
    bus.i_snoop_qhit = 0; bus.s_busy_uncached_store = 0; bus.i_mem_readyn = 0;
    bus.i_lb_qhit = 0; bus.i_lb_qdata = '0;
  endtask

  // Full miss sequence: accept, request, wait, hit, late writeback
  task automatic do_miss(input logic [31:0] va, input logic sgn, input logic [1:0] w,
                         input logic [31:0] qd, input logic [31:0] pa, input logic unc,
                         input logic [31:0] res, input logic [3:0] rob);
    bus.i_valid = 1; bus.i_ready = 1; bus.i_load = 1; bus.i_lsmiss = 1;
    bus.i_lssigned = sgn; bus.i_lswidth = w; bus.i_value = va;
    bus.i_fid = 8'h3C; bus.i_rob = rob;
    #1;
    chk("miss_idle_en", bus.o_en, 0);
    chk("miss_idle_req", bus.o_rdctrl_en, 0);
    cyc();
    chk("req_en", bus.o_rdctrl_en, 1);
    chk("req_addr", bus.o_rdctrl_addr, pa);
    chk("req_unc", bus.o_rdctrl_uncached, unc);
    chk("req_fid", bus.o_rdctrl_fid, 8'h3C);
    chk("req_lsw", bus.o_rdctrl_lswidth, w);
    chk("req_no_commit", bus.o_en, 0);
    cyc();
    chk("wait_req_low", bus.o_rdctrl_en, 0);
    chk("wait_no_commit", bus.o_en, 0);
    bus.i_lb_qhit = 1; bus.i_lb_qdata = qd;
    #1;
    chk("lb_qaddr", bus.o_lb_qaddr, pa);
    chk("miss_commit", bus.o_en, 1);
    chk("miss_result", bus.o_result, res);
    cyc();
    bus.i_valid = 0; bus.i_lb_qhit = 0; bus.i_load = 0; bus.i_lsmiss = 0;
    #1;
    chk("nowb_en", bus.o_nowb_en, 1);
    chk("nowb_rob", bus.o_nowb_rob, rob);
    chk("nowb_value", bus.o_nowb_value, res);
    cyc();
    chk("nowb_once", bus.o_nowb_en, 0);
  endtask

  initial begin
    total = 0; bad = 0;
    clr();
    resetn = 0;
    cyc(); cyc();
    chk("rst_bco", bus.o_bco_valid, 0);
    chk("rst_nowb", bus.o_nowb_en, 0);
    chk("rst_req", bus.o_rdctrl_en, 0);
    chk("rst_en", bus.o_en, 0);
    resetn = 1;
    cyc();

    // ALU op with residual delay, then ready
    bus.i_valid = 1; bus.i_ready = 1; bus.i_value = 32'h1234; bus.i_pc = 32'h80;
    bus.i_cmtdelay = 4'd2; bus.i_fid = 8'h11; bus.i_dst = 5'd7;
    #1;
    chk("alu_delay_en", bus.o_en, 0);
    chk("snoop_addr", bus.o_snoop_qaddr, 32'h80);
    bus.i_cmtdelay = 4'd0; bus.i_snoop_qhit = 1;
    #1;
    chk("snoop_block", bus.o_en, 0);
    bus.i_snoop_qhit = 0;
    #1;
    chk("alu_en", bus.o_en, 1);
    chk("alu_result", bus.o_result, 32'h1234);
    chk("alu_store", bus.o_store, 0);
    chk("alu_fid", bus.o_fid, 8'h11);
    chk("alu_dst", bus.o_dst, 5'd7);

    // Store held back by the store path for three cycles
    bus.i_store = 1; bus.i_mem_readyn = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("st_blocked", bus.o_mem_store_en, 0);
      cyc();
    end
    bus.i_mem_readyn = 0;
    #1;
    chk("st_en", bus.o_en, 1);
    chk("st_store", bus.o_store, 1);
    chk("st_release", bus.o_mem_store_en, 1);
    cyc();
    bus.i_valid = 0; bus.i_store = 0;
    #1;
    chk("st_once", bus.o_mem_store_en, 0);

    // Load whose data was forwarded at execute
    bus.i_valid = 1; bus.i_load = 1; bus.i_value = 32'h55;
    #1;
    chk("ld_hit_en", bus.o_en, 1);
    chk("ld_hit_res", bus.o_result, 32'h55);
    chk("ld_hit_noreq", dut.w_go_req, 0);
    cyc();
    bus.i_valid = 0; bus.i_load = 0;

    // Signed byte miss through the uncached window, then cached unsigned half
    do_miss(32'hA000_0003, 1'b1, 2'b00, 32'h80FF_FFFF, 32'h0000_0003, 1'b1, 32'hFFFF_FF80, 4'd5);
    do_miss(32'h0000_1002, 1'b0, 2'b01, 32'hBEEF_1234, 32'h0000_1002, 1'b0, 32'h0000_BEEF, 4'd9);

    // Uncached miss stalls while an uncached store is buffered
    bus.i_valid = 1; bus.i_ready = 1; bus.i_load = 1; bus.i_lsmiss = 1;
    bus.i_lswidth = 2'b10; bus.i_value = 32'hA000_0010; bus.s_busy_uncached_store = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("busy_noreq", bus.o_rdctrl_en, 0);
    end
    bus.s_busy_uncached_store = 0;
    cyc();
    chk("busy_drop_req", bus.o_rdctrl_en, 1);
    chk("busy_drop_addr", bus.o_rdctrl_addr, 32'h10);

    // Flush while waiting for the refill
    bus.s_busy_uncached_store = 1;
    cyc();
    bus.i_flush = 1; bus.i_lb_qhit = 1; bus.i_lb_qdata = 32'hCAFE_F00D;
    #1;
    chk("flush_no_commit", bus.o_en, 0);
    cyc();
    bus.i_flush = 0;
    #1;
    chk("flush_idle_en", bus.o_en, 0);
    chk("flush_nowb", bus.o_nowb_en, 0);
    chk("flush_noreq", bus.o_rdctrl_en, 0);
    cyc();
    chk("flush_nowb2", bus.o_nowb_en, 0);
    clr();

    // Branch with override info, then its delay slot
    bus.i_valid = 1; bus.i_ready = 1; bus.i_pc = 32'h100;
    bus.i_bco_valid = 1; bus.i_bco_taken = 1; bus.i_bco_pattern = 2'b10;
    bus.i_bco_target = 32'h400;
    #1;
    chk("br_en", bus.o_en, 1);
    cyc();
    bus.i_pc = 32'h104; bus.i_bco_valid = 0; bus.i_bco_target = 32'h0;
    bus.i_bco_taken = 0; bus.i_bco_pattern = 2'b00;
    #1;
    chk("ds_en", bus.o_en, 1);
    chk("ds_bco_early", bus.o_bco_valid, 0);
    cyc();
    bus.i_pc = 32'h108;
    #1;
    chk("bco_valid", bus.o_bco_valid, 1);
    chk("bco_pc", bus.o_bco_pc, 32'h100);
    chk("bco_target", bus.o_bco_target, 32'h400);
    chk("bco_taken", bus.o_bco_taken, 1);
    chk("bco_pattern", bus.o_bco_pattern, 2'b10);
    chk("bco_block", bus.o_en, 0);
    cyc();
    chk("bco_once", bus.o_bco_valid, 0);
    chk("bco_resume", bus.o_en, 1);
    cyc();
    chk("bco_no_repeat", bus.o_bco_valid, 0);
    clr();

    // Reset while waiting for a refill discards the miss
    bus.i_valid = 1; bus.i_ready = 1; bus.i_load = 1; bus.i_lsmiss = 1;
    bus.i_value = 32'h0000_2000;
    cyc(); cyc();
    resetn = 0;
    cyc();
    resetn = 1;
    bus.i_valid = 0;
    #1;
    chk("rstw_nowb", bus.o_nowb_en, 0);
    chk("rstw_req", bus.o_rdctrl_en, 0);
    bus.i_valid = 1; bus.i_lb_qhit = 1; bus.s_busy_uncached_store = 0;
    bus.i_value = 32'hA000_2000; bus.s_busy_uncached_store = 1;
    #1;
    chk("rstw_no_commit", bus.o_en, 0);
    cyc();
    chk("rstw_nowb2", bus.o_nowb_en, 0);
    clr();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/commit_unit_p.md
COMMIT_UNIT_P -- requirements
Module: commit_unit_p

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and address width (minimum 32).
REQ-002 SHALL have parameter ROB_W, default 4, ROB index width.
REQ-003 SHALL have parameter FID_W, default 8, fetch-id width.
REQ-004 SHALL have parameter DST_W, default 5, architectural register index width.
REQ-005 SHALL have parameter DLY_W, default 4, commit-delay field width.
REQ-006 SHALL have ports, one clock, reset synchronous active-low:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- i_flush  in  1  pipeline flush, abandons in-flight load miss
- i_valid, i_ready  in  1 each  ROB head valid / result ready
- i_pc  in  XLEN  head PC
- i_rob  in  ROB_W  head ROB index
- i_dst  in  DST_W  head destination
- i_value  in  XLEN  result, or load/store virtual address
- i_fid  in  FID_W  head fetch id
- i_load, i_store, i_lssigned  in  1 each  op class; signed load
- i_lswidth  in  2  00 byte, 01 half, 10 word
- i_lsmiss  in  1  load data not forwarded at execute
- i_cmtdelay  in  DLY_W  residual commit delay
- i_bco_valid, i_bco_taken  in  1 each  branch override info
- i_bco_pattern  in  2  predictor pattern
- i_bco_target  in  XLEN  branch target
- i_snoop_qhit  in  1  post-commit snoop table hit on i_pc
- s_busy_uncached_store  in  1  store buffer holds uncached store
- i_mem_readyn  in  1  store path not ready (active-low ready)
- i_lb_qhit  in  1  load buffer hit
- i_lb_qdata  in  XLEN  load buffer word
- o_snoop_qaddr  out  XLEN  equals i_pc
- o_lb_qaddr  out  XLEN  physical load address
- o_en, o_store  out  1 each  commit strobe; committed op is store
- o_fid, o_dst, o_result  out  FID_W/DST_W/XLEN  committed fields
- o_mem_store_en  out  1  store release
- o_rdctrl_en, o_rdctrl_uncached  out  1 each  refill request; uncached
- o_rdctrl_fid, o_rdctrl_addr, o_rdctrl_lswidth  out  FID_W/XLEN/2  request fields
- o_nowb_en, o_nowb_rob, o_nowb_value  out  1/ROB_W/XLEN  registered late load writeback
- o_bco_valid, o_bco_taken, o_bco_pattern, o_bco_pc, o_bco_target  out  registered branch override

Function
REQ-007 SHALL define base = i_valid & i_ready & (i_cmtdelay==0) & ~o_bco_valid & ~i_snoop_qhit & ~i_flush.
REQ-008 SHALL commit a non-memory op when base; o_store=0, o_result=i_value.
REQ-009 SHALL commit a store when base & ~i_mem_readyn; o_store=1; o_mem_store_en=o_en&i_store, same cycle.
REQ-010 SHALL commit a load with ~i_lsmiss when base, o_result=i_value.
REQ-011 SHALL translate: i_value[31:30]==2'b10 -> paddr={3'b000,i_value[28:0]}, uncached=i_value[29]; else paddr=i_value, uncached=0.
REQ-012 SHALL run a load-miss FSM IDLE/REQ/WAIT; transitions below evaluated in priority order.
REQ-013 IDLE: base & i_load & i_lsmiss & ~(uncached & s_busy_uncached_store) -> REQ; otherwise hold IDLE.
REQ-014 REQ: o_rdctrl_en=1 for exactly one cycle with fid/paddr/uncached/lswidth; next state WAIT.
REQ-015 WAIT: base & i_lb_qhit (o_lb_qaddr=paddr) -> commit load (o_en=1), return IDLE; else hold.
REQ-016 i_flush in any state SHALL force IDLE next cycle with no commit and no request.
REQ-017 Miss load result SHALL be extracted from i_lb_qdata at paddr[1:0] (byte) or paddr[1] (half); zero- or sign-extended per i_lssigned; word unmodified.
REQ-018 o_nowb_en SHALL assert the cycle after a miss-load commit, carrying i_rob and extracted result.
REQ-019 On commit with i_bco_valid, SHALL latch pc/pattern/taken/target and set pending.
REQ-020 On next commit (delay slot) with pending set, SHALL clear pending; o_bco_* registered, valid for one cycle after that commit.
REQ-021 While o_bco_valid=1, base=0 (no commit).
REQ-022 i_flush SHALL clear pending; it does not cancel an already-registered o_bco_valid.
REQ-023 o_snoop_qaddr=i_pc combinationally.

Reset
REQ-024 resetn low at clk edge SHALL set FSM IDLE, pending=0, o_bco_valid=0, o_nowb_en=0, o_rdctrl_en=0; data registers unspecified.
REQ-025 Reset mid-WAIT SHALL discard the miss; no later o_nowb_en for it.

Verification
REQ-026 ALU op, i_cmtdelay=2 then 0 -> o_en only when 0; o_result=i_value.
REQ-027 Store, i_mem_readyn=1 for 3 cycles then 0 -> o_mem_store_en one cycle, after readyn falls.
REQ-028 Byte load, signed, i_value=0xA0000003, miss -> o_rdctrl_addr=0x00000003, uncached=1; i_lb_qdata=0x80FFFFFF, qhit -> o_result=0xFFFFFF80; o_nowb_en next cycle.
REQ-029 Branch with bco commit, then delay slot commit -> o_bco_valid one cycle later with latched pc/target; head commit blocked that cycle.
REQ-030 Uncached load miss with s_busy_uncached_store=1 -> no o_rdctrl_en until busy drops.
REQ-031 i_flush during WAIT -> IDLE next cycle; no o_en, no o_nowb_en.
